// File: rtl/tank_pkg.sv
// Shared constants for the tank mover: fixed-point layout, rotation/quadrant
// encoding and the 16-entry sine table used for heading-to-velocity conversion.
package tank_pkg;

    localparam int unsigned FP_W   = 12;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned INT_W  = FP_W - FRAC_W;
    localparam int unsigned ROT_W  = 4;
    localparam int unsigned SIN_W  = 5;

    localparam logic [ROT_W-1:0] ROT_QUARTER = 4'd4;

    typedef enum logic [1:0] {
        QUAD_0,
        QUAD_1,
        QUAD_2,
        QUAD_3
    } quadrant_t;

    // round(8*sin(i*22.5 deg))
    function automatic logic signed [SIN_W-1:0] sin_lut(input logic [ROT_W-1:0] idx);
        case (idx)
            4'd0:    sin_lut =  5'sd0;
            4'd1:    sin_lut =  5'sd3;
            4'd2:    sin_lut =  5'sd6;
            4'd3:    sin_lut =  5'sd7;
            4'd4:    sin_lut =  5'sd8;
            4'd5:    sin_lut =  5'sd7;
            4'd6:    sin_lut =  5'sd6;
            4'd7:    sin_lut =  5'sd3;
            4'd8:    sin_lut =  5'sd0;
            4'd9:    sin_lut = -5'sd3;
            4'd10:   sin_lut = -5'sd6;
            4'd11:   sin_lut = -5'sd7;
            4'd12:   sin_lut = -5'sd8;
            4'd13:   sin_lut = -5'sd7;
            4'd14:   sin_lut = -5'sd6;
            default: sin_lut = -5'sd3;
        endcase
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Per-bit switch filter: samples on each strobe and accepts a new level only
// after two consecutive equal samples.
module switch_debouncer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    logic [WIDTH-1:0] last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last   <= '0;
            stable <= '0;
        end else if (sample) begin
            last <= raw;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (raw[i] == last[i]) stable[i] <= raw[i];
            end
        end
    end

endmodule

// File: rtl/tank_mover.sv
// Tank sprite mover: per-frame rotation/speed/position update, collision
// rollback and renderer sequencing. Define TANK_DEBOUNCE_EN to filter switches.
module tank_mover
    import tank_pkg::*;
#(
    parameter int unsigned INIT_X    = 128,
    parameter int unsigned INIT_Y    = 120,
    parameter int unsigned TURN_DIV  = 4,
    parameter int unsigned MAX_SPEED = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       vsync,
    input  logic       switch_left,
    input  logic       switch_right,
    input  logic       switch_up,
    input  logic       playfield,
    input  logic       sprite_gfx,
    output logic       vstart,
    output logic       load,
    output logic       hstart,
    output logic       hmirror,
    output logic       vmirror,
    output logic [2:0] bitmap_num,
    output logic [7:0] player_x,
    output logic [7:0] player_y,
    output logic [3:0] rotation,
    output logic       collided
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SPD_W = 4;

    logic                    vsync_q, vsync_qq, tick;
    logic                    left, right, up;
    logic [CNT_W-1:0]        turn_cnt, turn_cnt_nxt;
    logic [ROT_W-1:0]        rot_nxt;
    logic [SPD_W-1:0]        speed, speed_nxt;
    logic [FP_W-1:0]         pos_x, pos_y, save_x, save_y;
    logic signed [FP_W-1:0]  sin_x, sin_y, spd_ext, delta_x, delta_y;
    logic                    coll_hit;

`ifdef TANK_DEBOUNCE_EN
    logic [2:0] sw_stable;

    switch_debouncer #(.WIDTH(3)) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .sample (tick),
        .raw    ({switch_up, switch_right, switch_left}),
        .stable (sw_stable)
    );

    assign {up, right, left} = sw_stable;
`else
    assign left  = switch_left;
    assign right = switch_right;
    assign up    = switch_up;
`endif

    assign tick     = vsync_q & ~vsync_qq;
    assign coll_hit = sprite_gfx & playfield & ~hpos[8] & (vpos < 9'd240);
    assign player_x = pos_x[FP_W-1:FRAC_W];
    assign player_y = pos_y[FP_W-1:FRAC_W];

    always_comb begin
        turn_cnt_nxt = turn_cnt + CNT_W'(1);
        rot_nxt      = rotation;
        if (turn_cnt == CNT_W'(TURN_DIV - 1)) begin
            turn_cnt_nxt = '0;
            if (left && !right)      rot_nxt = rotation - ROT_W'(1);
            else if (right && !left) rot_nxt = rotation + ROT_W'(1);
        end

        speed_nxt = speed;
        if (collided) begin
            speed_nxt = '0;
        end else if (up) begin
            if (speed != SPD_W'(MAX_SPEED)) speed_nxt = speed + SPD_W'(1);
        end else if (speed != '0) begin
            speed_nxt = speed - SPD_W'(1);
        end

        // Velocity follows the heading and speed that take effect on this tick.
        sin_x   = FP_W'(sin_lut(rot_nxt));
        sin_y   = FP_W'(sin_lut(rot_nxt + ROT_QUARTER));
        spd_ext = signed'(FP_W'(speed_nxt));
        delta_x = sin_x * spd_ext;
        delta_y = -(sin_y * spd_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            collided <= 1'b0;
            turn_cnt <= '0;
            rotation <= '0;
            speed    <= '0;
            pos_x    <= {INT_W'(INIT_X), FRAC_W'(0)};
            pos_y    <= {INT_W'(INIT_Y), FRAC_W'(0)};
            save_x   <= {INT_W'(INIT_X), FRAC_W'(0)};
            save_y   <= {INT_W'(INIT_Y), FRAC_W'(0)};
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
            // A hit coinciding with a tick survives into the next frame.
            if (coll_hit)  collided <= 1'b1;
            else if (tick) collided <= 1'b0;
            if (tick) begin
                turn_cnt <= turn_cnt_nxt;
                rotation <= rot_nxt;
                speed    <= speed_nxt;
                if (collided) begin
                    pos_x <= save_x;
                    pos_y <= save_y;
                end else begin
                    save_x <= pos_x;
                    save_y <= pos_y;
                    pos_x  <= pos_x + delta_x;
                    pos_y  <= pos_y + delta_y;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vstart <= 1'b0;
            load   <= 1'b0;
            hstart <= 1'b0;
        end else begin
            vstart <= (vpos == {1'b0, player_y}) && (hpos == '0);
            load   <= (hpos == 9'd256);
            hstart <= (hpos == {1'b0, player_x});
        end
    end

    always_comb begin
        bitmap_num = {1'b0, rotation[1:0]};
        hmirror    = 1'b0;
        vmirror    = 1'b0;
        case (quadrant_t'(rotation[3:2]))
            QUAD_0: ;
            QUAD_1: begin
                bitmap_num = 3'd0 - rotation[2:0];
                vmirror    = 1'b1;
            end
            QUAD_2: begin
                hmirror = 1'b1;
                vmirror = 1'b1;
            end
            QUAD_3: begin
                bitmap_num = 3'd0 - rotation[2:0];
                hmirror    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/tank_mover.md
TANK_MOVER -- requirements
Module: tank_mover

Interface
REQ-001 Parameter INIT_X, default 128: reset X pixel position.
REQ-002 Parameter INIT_Y, default 120: reset Y pixel position.
REQ-003 Parameter TURN_DIV, default 4: frames per rotation step while a turn switch is held.
REQ-004 Parameter MAX_SPEED, default 3: maximum speed level.
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- hpos, vpos  in  9 each  beam position.
- vsync  in  1  frame sync.
- switch_left, switch_right, switch_up  in  1 each  player controls, active-high.
- playfield  in  1  playfield pixel.
- sprite_gfx  in  1  renderer pixel output.
- vstart, load, hstart  out  1 each  renderer sequencing pulses.
- hmirror, vmirror  out  1 each  renderer mirror controls.
- bitmap_num  out  3  bitmap index 0..4.
- player_x, player_y  out  8 each  integer position.
- rotation  out  4  heading; 0 = up, increments clockwise.
- collided  out  1  collision latch.

Function
REQ-006 Position SHALL be held as 12-bit 8.4 fixed point per axis; player_x/player_y are the upper 8 bits.
REQ-007 Frame tick SHALL be a one-clk pulse on the registered vsync rising edge; all movement updates occur only on ticks.
REQ-008 The tick counter SHALL wrap at TURN_DIV-1; on wrap, left alone SHALL decrement rotation mod 16, right alone SHALL increment it, and left+right together or neither SHALL leave it unchanged.
REQ-009 On each tick, speed SHALL increment (saturating at MAX_SPEED) when up is held and decrement (saturating at 0) otherwise.
REQ-010 On each tick, delta_x SHALL equal SIN[rotation]*speed and delta_y SHALL equal -SIN[(rotation+4) mod 16]*speed, using the updated speed; both are in 1/16 px.
REQ-011 SIN[i] SHALL be round(8*sin(i*22.5 deg)), signed 5-bit (range -8..8).
REQ-012 Position addition SHALL be mod 4096 per axis, so the sprite wraps across screen edges.
REQ-013 The block SHALL store the pre-update position on every tick.
REQ-014 collided SHALL set when sprite_gfx and playfield are both 1 with hpos<256 and vpos<240.
REQ-015 On a tick with collided=1, the block SHALL restore the stored position, force speed to 0, skip movement, and clear collided; rotation still updates.
REQ-016 A collision in the same cycle as the tick SHALL be counted in the next frame.
REQ-017 vstart SHALL be registered and pulse one clk when vpos==player_y and hpos==0.
REQ-018 load SHALL pulse one clk when hpos==256.
REQ-019 hstart SHALL pulse one clk when hpos==player_x.
REQ-020 The rotation-to-bitmap mapping SHALL be:
- quadrant 0 (rotation 0..3): bitmap=rotation[1:0], no mirror.
- quadrant 1: bitmap=-rotation[2:0], vmirror=1.
- quadrant 2: bitmap=rotation[1:0], hmirror=1, vmirror=1.
- quadrant 3: bitmap=-rotation[2:0], hmirror=1.

Reset
REQ-021 Reset SHALL set position to (INIT_X, INIT_Y) with fraction 0, and stored position to the same value.
REQ-022 Reset SHALL clear rotation, speed, tick counter, collided, all pulses, and the registered vsync.
REQ-023 Reset mid-frame SHALL abandon any pending update; no stale tick SHALL fire after release.

Configuration
REQ-024 With TANK_DEBOUNCE_EN defined, each switch SHALL be sampled on ticks and a change accepted only after 2 consecutive equal samples.
REQ-025 Without TANK_DEBOUNCE_EN, switches SHALL be sampled raw on each tick.

Structure
REQ-026 The SIN table, rotation/quadrant constants, and fixed-point width SHALL live in shared package tank_pkg.
REQ-027 Debounce logic SHALL be sub-module switch_debouncer, instantiated only under TANK_DEBOUNCE_EN.

Verification
REQ-028 Reset: player_x=128, player_y=120, rotation=0, collided=0, no pulses.
REQ-029 Turning: right held 8 frames -> rotation=2; left+right held 8 frames -> unchanged; left from 0 -> 15.
REQ-030 Straight motion: up held at rotation 0 for 4 frames, speed 1,2,3,3 -> y fixed 1920-72=1848, player_y=115, player_x=128.
REQ-031 Wrap: player_y=0 moving up at speed 3 -> player_y=255 next tick.
REQ-032 Collision: sprite_gfx=playfield=1 at hpos=50, vpos=60 -> collided=1; next tick restores previous position, speed=0, collided=0.
REQ-033 Timing: position (128,120) -> vstart at vpos=120/hpos=0, load at hpos=256, hstart at hpos=128; rotation=6 -> bitmap=2, vmirror=1, hmirror=0.
